// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester BRAM port arbiter.
// Holds per-memory default geometry and the requester index constants.
package mem_port_arbiter_pkg;

    // Default geometry of each accelerator memory (data bits / address bits).
    localparam int MEM0_DWIDTH = 112;
    localparam int MEM0_AWIDTH = 13;
    localparam int MEM1_DWIDTH = 112;
    localparam int MEM1_AWIDTH = 11;
    localparam int MEM2_DWIDTH = 112;
    localparam int MEM2_AWIDTH = 10;

    // Requester index type and the two requester identities.
    typedef logic req_idx_t;

    localparam req_idx_t REQ_GEMM = 1'b0;
    localparam req_idx_t REQ_HOST = 1'b1;

    // In a two-requester round robin the preferred winner is the one
    // that did not win last.
    function automatic req_idx_t other_req(input req_idx_t idx);
        return (idx == REQ_GEMM) ? REQ_HOST : REQ_GEMM;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way grant decision with burst lock.
// Default build: round robin on contention, tracked in r_last_gnt.
// MEM_ARB_FIXED_PRIORITY_EN: requester 0 always wins contention; lock kept.
// The grant is combinational; no grant is issued while rst_n is low.
module mem_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_ce,
    input  logic [1:0] i_lock,
    output logic       o_gnt_valid,
    output req_idx_t   o_gnt_idx
);

    logic     r_lock_valid;
    req_idx_t r_lock_owner;
    logic     w_lock_hold;
    logic     w_valid;
    req_idx_t w_idx;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    req_idx_t r_last_gnt;
`endif

    // Last cycle's winner keeps the port while it holds both lock and ce.
    assign w_lock_hold = r_lock_valid & i_ce[r_lock_owner];

    // Pick this cycle's winner: lock owner first, then single or contended request.
    always_comb begin
        w_valid = 1'b0;
        w_idx   = REQ_GEMM;
        if (!rst_n) begin
            w_valid = 1'b0;
            w_idx   = REQ_GEMM;
        end else if (w_lock_hold) begin
            w_valid = 1'b1;
            w_idx   = r_lock_owner;
        end else begin
            case (i_ce)
                2'b01: begin
                    w_valid = 1'b1;
                    w_idx   = REQ_GEMM;
                end
                2'b10: begin
                    w_valid = 1'b1;
                    w_idx   = REQ_HOST;
                end
                2'b11: begin
                    w_valid = 1'b1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                    w_idx   = REQ_GEMM;
`else
                    w_idx   = other_req(r_last_gnt);
`endif
                end
                default: begin
                    w_valid = 1'b0;
                    w_idx   = REQ_GEMM;
                end
            endcase
        end
    end

    // Remember whether the current winner asked to keep the port next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= REQ_GEMM;
        end else if (w_valid) begin
            r_lock_valid <= i_lock[w_idx];
            r_lock_owner <= w_idx;
        end else begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= r_lock_owner;
        end
    end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    // Track the last winner; reset value makes requester 0 win first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= REQ_HOST;
        end else if (w_valid) begin
            r_last_gnt <= w_idx;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end
`endif

    assign o_gnt_valid = w_valid;
    assign o_gnt_idx   = w_idx;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port between the GEMM core (req0) and the host loader (req1).
// Grant and port muxing are combinational; read-data valid is registered one
// cycle after a granted read and routed to the requester that issued it.
// Optional macro: MEM_ARB_FIXED_PRIORITY_EN (requester 0 wins contention).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DWIDTH = MEM2_DWIDTH,
    parameter int AWIDTH = MEM2_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_ce,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_d,
    output logic              req0_gnt,
    output logic [DWIDTH-1:0] req0_q,
    output logic              req0_qvalid,

    input  logic              req1_ce,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_d,
    output logic              req1_gnt,
    output logic [DWIDTH-1:0] req1_q,
    output logic              req1_qvalid,

    output logic              mem_ce,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q
);

    logic     w_gnt_valid;
    req_idx_t w_gnt_idx;
    logic     r_qvalid0;
    logic     r_qvalid1;

    mem_arb_rr2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ce        ({req1_ce, req0_ce}),
        .i_lock      ({req1_lock, req0_lock}),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign req0_gnt = w_gnt_valid & (w_gnt_idx == REQ_GEMM);
    assign req1_gnt = w_gnt_valid & (w_gnt_idx == REQ_HOST);

    // Steer the winner onto the BRAM port; an idle port drives all zeros.
    always_comb begin
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_d    = '0;
        if (req1_gnt) begin
            mem_ce   = 1'b1;
            mem_we   = req1_we;
            mem_addr = req1_addr;
            mem_d    = req1_d;
        end else if (req0_gnt) begin
            mem_ce   = 1'b1;
            mem_we   = req0_we;
            mem_addr = req0_addr;
            mem_d    = req0_d;
        end else begin
            mem_ce   = 1'b0;
            mem_we   = 1'b0;
            mem_addr = '0;
            mem_d    = '0;
        end
    end

    // Flag read data for the requester whose read was granted last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qvalid0 <= 1'b0;
            r_qvalid1 <= 1'b0;
        end else begin
            r_qvalid0 <= req0_gnt & ~req0_we;
            r_qvalid1 <= req1_gnt & ~req1_we;
        end
    end

    assign req0_qvalid = r_qvalid0;
    assign req1_qvalid = r_qvalid1;

    // Both requesters see the raw BRAM output; qvalid qualifies it.
    assign req0_q = mem_q;
    assign req1_q = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A behavioural BRAM returns
// 0xA5A50000 + addr one cycle after each read so read data is predictable.
module tb_mem_port_arbiter;

    localparam int DW = 112;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_ce = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_d = '0;
    logic          req0_gnt, req0_qvalid;
    logic [DW-1:0] req0_q;
    logic          req1_ce = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_d = '0;
    logic          req1_gnt, req1_qvalid;
    logic [DW-1:0] req1_q;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q = '0;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_ce(req0_ce), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_d(req0_d), .req0_gnt(req0_gnt),
        .req0_q(req0_q), .req0_qvalid(req0_qvalid),
        .req1_ce(req1_ce), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_d(req1_d), .req1_gnt(req1_gnt),
        .req1_q(req1_q), .req1_qvalid(req1_qvalid),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // BRAM stand-in: synchronous read returning an address-derived pattern.
    always @(posedge clk) begin
        if (mem_ce && !mem_we)
            mem_q <= 112'hA5A5_0000 + {{(DW-AW){1'b0}}, mem_addr};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic ce, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_ce = ce; req0_we = we; req0_lock = lk; req0_addr = a; req0_d = d;
    endtask

    task automatic drv1(input logic ce, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_ce = ce; req1_we = we; req1_lock = lk; req1_addr = a; req1_d = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Reset state, with req0 already requesting: nothing may be granted.
        drv0(1'b1, 1'b0, 1'b0, 10'd5, 112'h0);
        #2;
        chk("rst_gnt0", req0_gnt, 1'b0);
        chk("rst_mem_ce", mem_ce, 1'b0);
        chk("rst_mem_addr", mem_addr, 10'd0);
        chk("rst_qvalid0", req0_qvalid, 1'b0);
        chk("rst_qvalid1", req1_qvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
        // Fixed priority: req0 wins every contended cycle.
        for (int i = 0; i < 3; i++) begin
            nxt();
            drv0(1'b1, 1'b0, 1'b0, 10'd3, 112'h0);
            drv1(1'b1, 1'b0, 1'b0, 10'd7, 112'h0);
            settle();
            chk("fix_gnt0", req0_gnt, 1'b1);
            chk("fix_gnt1", req1_gnt, 1'b0);
        end
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("fix_qv0", req0_qvalid, 1'b1);
        chk("fix_qv1", req1_qvalid, 1'b0);
`else
        // First contention after reset: req0 write, then req1 read.
        nxt();
        drv0(1'b1, 1'b1, 1'b0, 10'd3, 112'hAA);
        drv1(1'b1, 1'b0, 1'b0, 10'd7, 112'h0);
        settle();
        chk("c1_gnt0", req0_gnt, 1'b1);
        chk("c1_gnt1", req1_gnt, 1'b0);
        chk("c1_mem_d", mem_d, 112'hAA);
        chk("c1_mem_we", mem_we, 1'b1);
        chk("c1_mem_addr", mem_addr, 10'd3);
        nxt();
        settle();
        chk("c2_gnt1", req1_gnt, 1'b1);
        chk("c2_gnt0", req0_gnt, 1'b0);
        chk("c2_mem_addr", mem_addr, 10'd7);
        chk("c2_mem_we", mem_we, 1'b0);
        chk("c2_wr_noqv0", req0_qvalid, 1'b0);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("c3_qv1", req1_qvalid, 1'b1);
        chk("c3_qv0", req0_qvalid, 1'b0);
        chk("c3_q1", req1_q, 112'hA5A5_0007);
`endif

        // Single req0 read at address 5.
        nxt();
        drv0(1'b1, 1'b0, 1'b0, 10'd5, 112'h0);
        settle();
        chk("s_gnt0", req0_gnt, 1'b1);
        chk("s_gnt1", req1_gnt, 1'b0);
        chk("s_mem_ce", mem_ce, 1'b1);
        chk("s_mem_addr", mem_addr, 10'd5);
        chk("s_mem_we", mem_we, 1'b0);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("s_qv0", req0_qvalid, 1'b1);
        chk("s_qv1", req1_qvalid, 1'b0);
        chk("s_q0", req0_q, 112'hA5A5_0005);
        chk("idle_mem_ce", mem_ce, 1'b0);
        chk("idle_mem_addr", mem_addr, 10'd0);
        chk("idle_mem_d", mem_d, 112'h0);

`ifndef MEM_ARB_FIXED_PRIORITY_EN
        // req1 locked burst of 4 writes against a continuous req0 read.
        for (int i = 0; i < 4; i++) begin
            nxt();
            drv0(1'b1, 1'b0, 1'b0, 10'd9, 112'h0);
            drv1(1'b1, 1'b1, 1'b1, 10'(i), 112'h0);
            settle();
            chk("lk_gnt1", req1_gnt, 1'b1);
            chk("lk_gnt0", req0_gnt, 1'b0);
            chk("lk_addr", mem_addr, 10'(i));
        end
        nxt();
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("lk5_gnt0", req0_gnt, 1'b1);
        chk("lk5_addr", mem_addr, 10'd9);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("lk6_qv0", req0_qvalid, 1'b1);
        chk("lk6_q0", req0_q, 112'hA5A5_0009);
`endif

        // Alternating reads 10/20/30/40: qvalid alternates with matching data.
        nxt();
        drv0(1'b1, 1'b0, 1'b0, 10'd10, 112'h0);
        settle();
        chk("alt_gnt0", req0_gnt, 1'b1);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv1(1'b1, 1'b0, 1'b0, 10'd20, 112'h0);
        settle();
        chk("alt_gnt1", req1_gnt, 1'b1);
        chk("alt1_qv0", req0_qvalid, 1'b1);
        chk("alt1_qv1", req1_qvalid, 1'b0);
        chk("alt1_q0", req0_q, 112'hA5A5_000A);
        nxt();
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv0(1'b1, 1'b0, 1'b0, 10'd30, 112'h0);
        settle();
        chk("alt2_qv1", req1_qvalid, 1'b1);
        chk("alt2_qv0", req0_qvalid, 1'b0);
        chk("alt2_q1", req1_q, 112'hA5A5_0014);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv1(1'b1, 1'b0, 1'b0, 10'd40, 112'h0);
        settle();
        chk("alt3_qv0", req0_qvalid, 1'b1);
        chk("alt3_q0", req0_q, 112'hA5A5_001E);
        nxt();
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("alt4_qv1", req1_qvalid, 1'b1);
        chk("alt4_qv0", req0_qvalid, 1'b0);
        chk("alt4_q1", req1_q, 112'hA5A5_0028);

        // Reset asserted mid-cycle during a granted req0 read.
        nxt();
        drv0(1'b1, 1'b0, 1'b0, 10'd1, 112'h0);
        nxt();
        drv0(1'b1, 1'b0, 1'b0, 10'd5, 112'h0);
        settle();
        chk("r_gnt0", req0_gnt, 1'b1);
        chk("r_qv0_pre", req0_qvalid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r_qv0_async", req0_qvalid, 1'b0);
        chk("r_gnt0_inrst", req0_gnt, 1'b0);
        chk("r_mem_ce_inrst", mem_ce, 1'b0);
        nxt();
        chk("r_qv0_post", req0_qvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        nxt();
        drv0(1'b1, 1'b0, 1'b0, 10'd2, 112'h0);
        drv1(1'b1, 1'b0, 1'b0, 10'd6, 112'h0);
        settle();
        chk("r_cont_gnt0", req0_gnt, 1'b1);
        chk("r_cont_gnt1", req1_gnt, 1'b0);
        nxt();
        drv0(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        drv1(1'b0, 1'b0, 1'b0, 10'd0, 112'h0);
        settle();
        chk("r_cont_qv0", req0_qvalid, 1'b1);
        chk("r_cont_q0", req0_q, 112'hA5A5_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
